// File: rtl/cnt_arb_pkg.sv
// rtl/cnt_arb_pkg.sv - shared state encoding and default sizes for cnt_arb
package cnt_arb_pkg;

    localparam int DEF_NREQ  = 4;
    localparam int DEF_LEN_W = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_RUN   = 2'd2,
        S_LAST  = 2'd3
    } state_t;

endpackage

// File: rtl/cnt_arb_rr_pick.sv
// rtl/cnt_arb_rr_pick.sv - combinational round-robin picker (module rr_pick)
module rr_pick
    import cnt_arb_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int ID_W = $clog2(DEF_NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic            valid,
    output logic [ID_W-1:0] id
);

    // Scan from the farthest slot back to ptr+1 so the nearest set bit after ptr wins.
    always_comb begin
        valid = 1'b0;
        id    = '0;
        for (int k = NREQ; k >= 1; k--) begin
            if (req[(int'(ptr) + k) % NREQ]) begin
                valid = 1'b1;
                id    = ID_W'((int'(ptr) + k) % NREQ);
            end
        end
    end

endmodule

// File: rtl/cnt_arb.sv
// rtl/cnt_arb.sv - round-robin arbiter/sequencer for a shared count-to-N worker; optional CNT_ARB_LOCK_EN
module cnt_arb
    import cnt_arb_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int LEN_W = DEF_LEN_W,
    parameter int ID_W  = $clog2(DEF_NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*LEN_W-1:0] len_i,
`ifdef CNT_ARB_LOCK_EN
    input  logic                  lock,
`endif
    output logic [NREQ-1:0]       gnt,
    output logic                  busy,
    output logic                  run,
    output logic [LEN_W-1:0]      cnt,
    output logic                  done,
    output logic [ID_W-1:0]       done_id
);

    state_t            state_q, state_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [ID_W-1:0]   ptr_q;
    logic [LEN_W-1:0]  len_q;
    logic              pick_valid;
    logic [ID_W-1:0]   pick_id;
    logic              hold_grant;

    rr_pick #(.NREQ(NREQ), .ID_W(ID_W)) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .id    (pick_id)
    );

    // Lock keeps the current owner when it still requests at the end of its job.
`ifdef CNT_ARB_LOCK_EN
    assign hold_grant = lock & req[id_q];
`else
    assign hold_grant = 1'b0;
`endif

    // Next-state decode; id_d is the owner of the job the next state belongs to.
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        case (state_q)
            S_IDLE: begin
                if (pick_valid) begin
                    state_d = S_GRANT;
                    id_d    = pick_id;
                end
            end
            S_GRANT: state_d = S_RUN;
            S_RUN:   if (cnt >= len_q) state_d = S_LAST;
            S_LAST:  state_d = hold_grant ? S_GRANT : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State, job context and outputs registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            id_q    <= '0;
            ptr_q   <= ID_W'(NREQ - 1);
            len_q   <= '0;
            gnt     <= '0;
            busy    <= 1'b0;
            run     <= 1'b0;
            cnt     <= '0;
            done    <= 1'b0;
            done_id <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            if (state_d == S_GRANT)
                len_q <= len_i[int'(id_d)*LEN_W +: LEN_W];
            if (state_q == S_LAST && state_d != S_GRANT)
                ptr_q <= id_q;
            gnt  <= (state_d == S_GRANT) ? (NREQ'(1) << id_d) : '0;
            busy <= (state_d != S_IDLE);
            run  <= (state_d == S_RUN);
            if (state_d == S_GRANT)
                cnt <= '0;
            else if (state_q == S_RUN && state_d == S_RUN)
                cnt <= cnt + LEN_W'(1);
            done <= (state_d == S_LAST);
            if (state_d == S_LAST)
                done_id <= id_q;
        end
    end

endmodule
